// File: rtl/counter_xn_pkg.sv
// Shared definitions for the multi-channel tick counter: mode encodings,
// bus width and the ceiling-log2 helper used to size the channel select.
package counter_xn_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_SQUARE   = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/counter_xn_if.sv
// Register-style access bus of the counter block: write strobe, select,
// write data and combinational readback.
interface counter_xn_if
    import counter_xn_pkg::*;
#(
    parameter int unsigned N_CH = 3
);
    localparam int unsigned SEL_W = clog2(N_CH + 1);

    logic              counter_we;
    logic [SEL_W-1:0]  counter_ch;
    logic [DATA_W-1:0] counter_val;
    logic [DATA_W-1:0] counter_out;

    modport master (output counter_we, counter_ch, counter_val, input counter_out);
    modport slave  (input counter_we, counter_ch, counter_val, output counter_out);
endinterface

// File: rtl/counter_xn_chan.sv
// One counter channel: synchronises its asynchronous tick source, detects
// rising edges and runs the down-counter with its terminal output.
module counter_xn_chan
    import counter_xn_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_src,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  mode_e            mode,
    input  logic             en,
    input  logic             out_clr,
    output logic [CNT_W-1:0] count,
    output logic             term_out
);

    logic [1:0]       sync_q;
    logic             prev_q;
    logic [1:0]       warm_q;
    logic [CNT_W-1:0] reload_q;
    logic             tick_c;
    logic             live_c;
    logic             term_c;

    // warm_q keeps the edge detector blind until prev_q holds a post-reset
    // sample, so a source already high at release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
            warm_q <= 2'd0;
        end else begin
            sync_q <= {sync_q[0], clk_src};
            prev_q <= sync_q[1];
            if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
        end
    end

    assign tick_c = sync_q[1] && !prev_q && (warm_q == 2'd3);
    assign live_c = tick_c && en && (mode != MODE_RSVD) && (count != '0);
    assign term_c = live_c && (count == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            reload_q <= '0;
            term_out <= 1'b0;
        end else if (load) begin
            count    <= load_val;
            reload_q <= load_val;
            term_out <= 1'b0;
        end else begin
            if (live_c) count <= term_c ? ((mode == MODE_ONESHOT) ? '0 : reload_q)
                                        : count - CNT_W'(1);
            // Periodic pulses last one cycle; mode change or reserved mode clears.
            if (mode == MODE_PERIODIC && !term_c) term_out <= 1'b0;
            if (term_c) begin
                case (mode)
                    MODE_ONESHOT:  term_out <= 1'b1;
                    MODE_PERIODIC: term_out <= 1'b1;
                    MODE_SQUARE:   term_out <= !term_out;
                    default:       term_out <= 1'b0;
                endcase
            end
            if (mode == MODE_RSVD || out_clr) term_out <= 1'b0;
        end
    end

endmodule

// File: rtl/counter_xn.sv
// N-channel programmable tick counter: control register, write decode and
// readback mux around N_CH independent channels.
module counter_xn
    import counter_xn_pkg::*;
#(
    parameter int unsigned N_CH  = 3,
    parameter int unsigned CNT_W = 32
) (
    input  logic            clk,
    input  logic            RSTN,
    input  logic [N_CH-1:0] clk_ch,
    counter_xn_if.slave     bus,
    output logic [N_CH-1:0] counter_OUT
);

    localparam int unsigned SEL_W  = clog2(N_CH + 1);
    localparam int unsigned CTRL_W = 3 * N_CH;

    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  counts [N_CH];
    logic              ctrl_wr_c;
    logic              unused_val_c;

    assign ctrl_wr_c    = bus.counter_we && (bus.counter_ch == SEL_W'(N_CH));
    // Data bits above the control word or count width are don't-care.
    assign unused_val_c = ^bus.counter_val;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            ctrl_q <= '0;
        end else if (ctrl_wr_c) begin
            ctrl_q <= bus.counter_val[CTRL_W-1:0];
        end
    end

    for (genvar gi = 0; gi < int'(N_CH); gi++) begin : g_chan
        counter_xn_chan #(.CNT_W(CNT_W)) u_chan (
            .clk      (clk),
            .rst_n    (RSTN),
            .clk_src  (clk_ch[gi]),
            .load     (bus.counter_we && (bus.counter_ch == SEL_W'(gi))),
            .load_val (bus.counter_val[CNT_W-1:0]),
            .mode     (mode_e'(ctrl_q[2*gi +: 2])),
            .en       (ctrl_q[2*N_CH + gi]),
            .out_clr  (ctrl_wr_c && (bus.counter_val[2*gi +: 2] != ctrl_q[2*gi +: 2])),
            .count    (counts[gi]),
            .term_out (counter_OUT[gi])
        );
    end

    // Combinational readback; unused select values read as zero.
    always_comb begin
        bus.counter_out = '0;
        if (bus.counter_ch == SEL_W'(N_CH)) bus.counter_out = DATA_W'(ctrl_q);
        for (int i = 0; i < int'(N_CH); i++) begin
            if (bus.counter_ch == SEL_W'(i)) bus.counter_out = DATA_W'(counts[i]);
        end
    end

endmodule
